// File: rtl/otter_io_pkg.sv
// otter_io_pkg: shared constants and helpers for the OTTER I/O hub.
// Holds the IOBUS address map, CTRL bit positions and the hex-to-segment
// glyph function used by the display scanner.
package otter_io_pkg;

  // Input side (read-only) registers
  localparam logic [31:0] ADDR_SWITCHES = 32'h1100_8000;
  localparam logic [31:0] ADDR_BUTTONS  = 32'h1100_8004;
  localparam logic [31:0] ADDR_BTN_EDGE = 32'h1100_8008;

  // Output side (read/write) registers
  localparam logic [31:0] ADDR_LEDS     = 32'h1100_C000;
  localparam logic [31:0] ADDR_SEGS     = 32'h1100_C004;
  localparam logic [31:0] ADDR_ANODES   = 32'h1100_C008;
  localparam logic [31:0] ADDR_HEX      = 32'h1100_C00C;
  localparam logic [31:0] ADDR_CTRL     = 32'h1100_C010;
  localparam logic [31:0] ADDR_IRQ_MASK = 32'h1100_C014;
  localparam logic [31:0] ADDR_EDGE_CLR = 32'h1100_C018;

  // CTRL layout: bit0 selects hex mode, bits[7:4] enable digits 0..3
  localparam int unsigned CTRL_HEX_BIT = 0;
  localparam int unsigned CTRL_EN_LSB  = 4;
  localparam int unsigned CTRL_EN_MSB  = 7;
  localparam logic [7:0]  CTRL_MASK    = 8'hF1;

  // Active-low glyph {dp,g,f,e,d,c,b,a}; dp always off
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/otter_io_hub_if.sv
// otter_io_hub_if: MCU IOBUS bundle between the OTTER core and the I/O hub.
//   IOBUS_ADDR/IOBUS_OUT/IOBUS_WR : address, write data, write strobe (MCU -> hub)
//   IOBUS_IN                      : combinational read data (hub -> MCU)
//   INTR                          : registered interrupt request (hub -> MCU)
interface otter_io_hub_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic        INTR;

  modport master (output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, input IOBUS_IN, INTR);
  modport slave  (input IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, output IOBUS_IN, INTR);
endinterface

// File: rtl/otter_debounce.sv
// otter_debounce: 2-FF synchroniser plus counting debouncer for one button.
//   CLK, RST : clock, synchronous active-high reset
//   din      : raw asynchronous button
//   dout     : debounced level
//   rise_c   : combinational pulse, high in the cycle dout is about to go 0->1
module otter_debounce #(
  parameter int unsigned DB_CYCLES = 10000
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic dout,
  output logic rise_c
);

  localparam int unsigned CW = $clog2(DB_CYCLES);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles that disagree with the current level; any
  // agreement restarts the count, so a bounce discards progress.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) lvl_d = s2_q;
      else                             cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= din;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout   = lvl_q;
  assign rise_c = lvl_d & ~lvl_q;

endmodule

// File: rtl/otter_io_hub.sv
// otter_io_hub: memory-mapped basys3 I/O peripheral for the OTTER MCU.
//   CLK, RST  : clock, synchronous active-high reset
//   iobus     : IOBUS slave (address/data/strobe in, read data and INTR out)
//   switches  : raw switches, 2-FF synchronised
//   buttons   : raw buttons, synchronised and debounced
//   leds      : LED register drive
//   segs, an  : active-low cathodes/anodes, raw or hardware hex scan
module otter_io_hub
  import otter_io_pkg::*;
#(
  parameter int unsigned NUM_SW       = 16,
  parameter int unsigned NUM_BTN      = 5,
  parameter int unsigned NUM_LED      = 16,
  parameter int unsigned DB_CYCLES    = 10000,
  parameter int unsigned REFRESH_BITS = 17
) (
  input  logic                 CLK,
  input  logic                 RST,
  otter_io_hub_if.slave        iobus,
  input  logic [NUM_SW-1:0]    switches,
  input  logic [NUM_BTN-1:0]   buttons,
  output logic [NUM_LED-1:0]   leds,
  output logic [7:0]           segs,
  output logic [3:0]           an
);

  logic [NUM_SW-1:0]       sw_s1_q, sw_s2_q;
  logic [NUM_BTN-1:0]      btn_lvl, btn_rise;
  logic [NUM_LED-1:0]      leds_q;
  logic [7:0]              seg_raw_q, ctrl_q;
  logic [3:0]              an_raw_q;
  logic [15:0]             hex_q;
  logic [NUM_BTN-1:0]      mask_q, edge_q, edge_d, clr_c;
  logic                    intr_q;
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [1:0]              digit;
  logic [3:0]              nibble;
  logic [7:0]              segs_q, segs_d;
  logic [3:0]              an_q, an_d;
  logic [31:0]             rdata;
  logic wr_leds, wr_segs, wr_an, wr_hex, wr_ctrl, wr_mask, wr_clr;

  // Per-button synchroniser + debouncer
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    otter_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .CLK    (CLK),
      .RST    (RST),
      .din    (buttons[i]),
      .dout   (btn_lvl[i]),
      .rise_c (btn_rise[i])
    );
  end

  // Exact-match write decode
  assign wr_leds = iobus.IOBUS_WR && (iobus.IOBUS_ADDR == ADDR_LEDS);
  assign wr_segs = iobus.IOBUS_WR && (iobus.IOBUS_ADDR == ADDR_SEGS);
  assign wr_an   = iobus.IOBUS_WR && (iobus.IOBUS_ADDR == ADDR_ANODES);
  assign wr_hex  = iobus.IOBUS_WR && (iobus.IOBUS_ADDR == ADDR_HEX);
  assign wr_ctrl = iobus.IOBUS_WR && (iobus.IOBUS_ADDR == ADDR_CTRL);
  assign wr_mask = iobus.IOBUS_WR && (iobus.IOBUS_ADDR == ADDR_IRQ_MASK);
  assign wr_clr  = iobus.IOBUS_WR && (iobus.IOBUS_ADDR == ADDR_EDGE_CLR);

  // Sticky edges: a new rise overrides a coincident clear
  assign clr_c  = wr_clr ? iobus.IOBUS_OUT[NUM_BTN-1:0] : '0;
  assign edge_d = (edge_q & ~clr_c) | btn_rise;

  // Read mux, zero-extended; EDGE_CLR and unmapped addresses read 0
  always_comb begin
    rdata = '0;
    case (iobus.IOBUS_ADDR)
      ADDR_SWITCHES: rdata = 32'(sw_s2_q);
      ADDR_BUTTONS:  rdata = 32'(btn_lvl);
      ADDR_BTN_EDGE: rdata = 32'(edge_q);
      ADDR_LEDS:     rdata = 32'(leds_q);
      ADDR_SEGS:     rdata = 32'(seg_raw_q);
      ADDR_ANODES:   rdata = 32'(an_raw_q);
      ADDR_HEX:      rdata = 32'(hex_q);
      ADDR_CTRL:     rdata = 32'(ctrl_q);
      ADDR_IRQ_MASK: rdata = 32'(mask_q);
      default:       rdata = '0;
    endcase
  end

  // Display source: raw registers or scanned hex digit
  assign digit  = refresh_q[REFRESH_BITS-1 -: 2];
  assign nibble = 4'(hex_q >> {digit, 2'b00});

  always_comb begin
    segs_d = seg_raw_q;
    an_d   = an_raw_q;
    if (ctrl_q[CTRL_HEX_BIT]) begin
      segs_d = hex_to_seg(nibble);
      an_d   = ~((4'b0001 << digit) & ctrl_q[CTRL_EN_MSB:CTRL_EN_LSB]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      leds_q    <= '0;
      seg_raw_q <= 8'hFF;
      an_raw_q  <= 4'hF;
      hex_q     <= '0;
      ctrl_q    <= '0;
      mask_q    <= '0;
      edge_q    <= '0;
      intr_q    <= 1'b0;
      refresh_q <= '0;
      segs_q    <= 8'hFF;
      an_q      <= 4'hF;
    end else begin
      sw_s1_q   <= switches;
      sw_s2_q   <= sw_s1_q;
      if (wr_leds) leds_q    <= iobus.IOBUS_OUT[NUM_LED-1:0];
      if (wr_segs) seg_raw_q <= iobus.IOBUS_OUT[7:0];
      if (wr_an)   an_raw_q  <= iobus.IOBUS_OUT[3:0];
      if (wr_hex)  hex_q     <= iobus.IOBUS_OUT[15:0];
      if (wr_ctrl) ctrl_q    <= iobus.IOBUS_OUT[7:0] & CTRL_MASK;
      if (wr_mask) mask_q    <= iobus.IOBUS_OUT[NUM_BTN-1:0];
      edge_q    <= edge_d;
      intr_q    <= |(edge_q & mask_q);
      refresh_q <= refresh_q + REFRESH_BITS'(1);
      segs_q    <= segs_d;
      an_q      <= an_d;
    end
  end

  assign iobus.IOBUS_IN = rdata;
  assign iobus.INTR     = intr_q;
  assign leds           = leds_q;
  assign segs           = segs_q;
  assign an             = an_q;

endmodule
